cnn_window_gen: RTL and testbench

- Streaming K×K sliding-window generator for the CNN datapath, sitting between the pixel source and the convolution PE array.
- Supersedes the fixed single-channel window buffer. Adds the following:
  - multi-channel pixels;
  - internal zero-padding insertion, so the source sends only real pixels;
  - stride support;
  - frame position tracking with explicit window-valid and frame-done indications.
- Input uses a valid/ready handshake; output is valid-only, and the downstream always accepts.

---
 rtl/cnn_pkg.sv | 16 +
 rtl/line_buffer.sv | 27 ++
 rtl/cnn_window_gen.sv | 177 +++++++++++++++++
 tb/tb_cnn_window_gen.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared types and frame-geometry helpers for the CNN window generator and
// the PE-array address generators.
package cnn_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} win_state_e;

   // Frame size once the zero border is added on both sides.
   function automatic int padded_dim(input int dim, input int pad);
      return dim + 2 * pad;
   endfunction

   function automatic int windows_per_axis(input int padded, input int kernel, input int stride);
      return (padded - kernel) / stride + 1;
   endfunction

endpackage

// File: rtl/line_buffer.sv
// Enable-gated shift register giving a fixed pBUFFER_WIDTH-advance delay,
// used to cascade older window rows.
module line_buffer #(
   parameter int pBUFFER_WIDTH = 1,
   parameter int pDATA_WIDTH   = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic [pDATA_WIDTH-1:0] data_in,
   output logic [pDATA_WIDTH-1:0] data_out
);

   logic [pDATA_WIDTH-1:0] mem [pBUFFER_WIDTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < pBUFFER_WIDTH; i++) mem[i] <= '0;
      end else if (en) begin
         mem[0] <= data_in;
         for (int i = 1; i < pBUFFER_WIDTH; i++) mem[i] <= mem[i-1];
      end
   end

   assign data_out = mem[pBUFFER_WIDTH-1];

endmodule

// File: rtl/cnn_window_gen.sv
// Streaming KxK sliding-window generator with internal zero padding and stride.
// Optional macro CNN_WINDOW_LAST_EN adds an out_last flag on the final window.
module cnn_window_gen
   import cnn_pkg::*;
#(
   parameter int pDATA_WIDTH   = 8,
   parameter int pIN_CHANNEL   = 1,
   parameter int pINPUT_WIDTH  = 640,
   parameter int pINPUT_HEIGHT = 480,
   parameter int pKERNEL_SIZE  = 3,
   parameter int pPADDING      = 1,
   parameter int pSTRIDE       = 1
) (
   input  logic                                                     clk,
   input  logic                                                     rst,
   input  logic                                                     in_valid,
   output logic                                                     in_ready,
   input  logic [pDATA_WIDTH*pIN_CHANNEL-1:0]                       data_in,
   output logic                                                     out_valid,
   output logic [pDATA_WIDTH*pIN_CHANNEL*pKERNEL_SIZE*pKERNEL_SIZE-1:0] data_out,
   output logic                                                     frame_done
`ifdef CNN_WINDOW_LAST_EN
   ,
   output logic                                                     out_last
`endif
);

   localparam int PIX = pDATA_WIDTH * pIN_CHANNEL;
   localparam int K   = pKERNEL_SIZE;
   localparam int S   = pSTRIDE;
   localparam int PW  = padded_dim(pINPUT_WIDTH, pPADDING);
   localparam int PH  = padded_dim(pINPUT_HEIGHT, pPADDING);
   localparam int RW  = $clog2(PH + 1);
   localparam int CW  = $clog2(PW + 1);
   localparam int SW  = (S > 1) ? $clog2(S) : 1;

   localparam logic [RW-1:0] ROW_LAST = RW'(PH - 1);
   localparam logic [RW-1:0] ROW_WIN  = RW'(K - 1);
   localparam logic [RW-1:0] ROW_LO   = RW'(pPADDING);
   localparam logic [RW-1:0] ROW_HI   = RW'(pPADDING + pINPUT_HEIGHT);
   localparam logic [CW-1:0] COL_LAST = CW'(PW - 1);
   localparam logic [CW-1:0] COL_WIN  = CW'(K - 1);
   localparam logic [CW-1:0] COL_LO   = CW'(pPADDING);
   localparam logic [CW-1:0] COL_HI   = CW'(pPADDING + pINPUT_WIDTH);
   localparam logic [SW-1:0] S_LAST   = SW'(S - 1);

   win_state_e     state;
   logic [RW-1:0]  row, next_row;
   logic [CW-1:0]  col, next_col;
   logic [SW-1:0]  rs, cs;
   logic           last_col, last_pos, advance, window_hit;
   logic [PIX-1:0] pix_in;
   logic [PIX-1:0] win    [K][K];
   logic [PIX-1:0] lb_out [K-1];

   function automatic logic interior(input logic [RW-1:0] r, input logic [CW-1:0] c);
      return (r >= ROW_LO) && (r < ROW_HI) && (c >= COL_LO) && (c < COL_HI);
   endfunction

   // in_ready is registered and always equals "current position is interior" in RUN,
   // so pad positions advance unconditionally with a zero pixel.
   assign last_col   = (col == COL_LAST);
   assign last_pos   = last_col && (row == ROW_LAST);
   assign next_col   = last_col ? '0 : col + 1'b1;
   assign next_row   = last_col ? row + 1'b1 : row;
   assign advance    = (state == RUN) && (!in_ready || in_valid);
   assign window_hit = (row >= ROW_WIN) && (col >= COL_WIN) && (rs == '0) && (cs == '0);
   assign pix_in     = in_ready ? data_in : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         row        <= '0;
         col        <= '0;
         rs         <= '0;
         cs         <= '0;
         in_ready   <= 1'b0;
         out_valid  <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         out_valid  <= 1'b0;
         frame_done <= 1'b0;
         case (state)
            IDLE: begin
               if (in_valid) begin
                  state    <= RUN;
                  row      <= '0;
                  col      <= '0;
                  rs       <= '0;
                  cs       <= '0;
                  in_ready <= interior('0, '0);
               end
            end
            RUN: begin
               if (advance) begin
                  out_valid <= window_hit;
                  if (last_col) begin
                     cs <= '0;
                     if (row >= ROW_WIN) rs <= (rs == S_LAST) ? '0 : rs + 1'b1;
                  end else if (col >= COL_WIN) begin
                     cs <= (cs == S_LAST) ? '0 : cs + 1'b1;
                  end
                  if (last_pos) begin
                     state      <= DONE;
                     in_ready   <= 1'b0;
                     frame_done <= 1'b1;
                  end else begin
                     row      <= next_row;
                     col      <= next_col;
                     in_ready <= interior(next_row, next_col);
                  end
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Column shift within each window row; row r>0 is fed by the line buffer of row r-1.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++) win[r][c] <= '0;
      end else if (advance) begin
         win[0][0] <= pix_in;
         for (int r = 1; r < K; r++) win[r][0] <= lb_out[r-1];
         for (int r = 0; r < K; r++)
            for (int c = 1; c < K; c++) win[r][c] <= win[r][c-1];
      end
   end

   for (genvar r = 1; r < K; r++) begin : g_line
      line_buffer #(
         .pBUFFER_WIDTH(PW - K),
         .pDATA_WIDTH  (PIX)
      ) u_line_buffer (
         .clk     (clk),
         .rst     (rst),
         .en      (advance),
         .data_in (win[r-1][K-1]),
         .data_out(lb_out[r-1])
      );
   end

   for (genvar r = 0; r < K; r++) begin : g_pack_row
      for (genvar c = 0; c < K; c++) begin : g_pack_col
         assign data_out[(r*K+c)*PIX +: PIX] = win[r][c];
      end
   end

`ifdef CNN_WINDOW_LAST_EN
   localparam int WPR = windows_per_axis(PW, K, S);
   localparam int WPC = windows_per_axis(PH, K, S);
   localparam int WCW = $clog2(WPR * WPC + 1);
   localparam logic [WCW-1:0] WIN_LAST = WCW'(WPR * WPC - 1);

   logic [WCW-1:0] win_count;

   // Window index restarts whenever the FSM is idle, i.e. before every frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         win_count <= '0;
         out_last  <= 1'b0;
      end else begin
         out_last <= 1'b0;
         if (state == IDLE) begin
            win_count <= '0;
         end else if (advance && window_hit) begin
            out_last  <= (win_count == WIN_LAST);
            win_count <= win_count + 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_cnn_window_gen.sv
// Self-checking bench: two DUTs (stride 1 / 3 channels, stride 2 / 1 channel)
// on a 4x4 frame, checked against a padded-image window model.
module tb_cnn_window_gen;

   localparam int W = 4, H = 4, K = 3, P = 1;
   localparam int PW = W + 2*P, PH = H + 2*P, NPIX = W * H;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst;
   logic         iv_a, ir_a, ov_a, fd_a;
   logic [23:0]  di_a;
   logic [215:0] do_a;
   logic         iv_b, ir_b, ov_b, fd_b;
   logic [7:0]   di_b;
   logic [71:0]  do_b;
`ifdef CNN_WINDOW_LAST_EN
   logic         ol_a, ol_b;
`endif

   cnn_window_gen #(
      .pDATA_WIDTH(8), .pIN_CHANNEL(3), .pINPUT_WIDTH(W), .pINPUT_HEIGHT(H),
      .pKERNEL_SIZE(K), .pPADDING(P), .pSTRIDE(1)
   ) dut_a (
      .clk(clk), .rst(rst), .in_valid(iv_a), .in_ready(ir_a), .data_in(di_a),
      .out_valid(ov_a), .data_out(do_a), .frame_done(fd_a)
`ifdef CNN_WINDOW_LAST_EN
      , .out_last(ol_a)
`endif
   );

   cnn_window_gen #(
      .pDATA_WIDTH(8), .pIN_CHANNEL(1), .pINPUT_WIDTH(W), .pINPUT_HEIGHT(H),
      .pKERNEL_SIZE(K), .pPADDING(P), .pSTRIDE(2)
   ) dut_b (
      .clk(clk), .rst(rst), .in_valid(iv_b), .in_ready(ir_b), .data_in(di_b),
      .out_valid(ov_b), .data_out(do_b), .frame_done(fd_b)
`ifdef CNN_WINDOW_LAST_EN
      , .out_last(ol_b)
`endif
   );

   int n_checks = 0;
   int n_errors = 0;
   logic [255:0] exp_q [$];

   task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Padded image: zero border, real pixel (r,c) = r*W+c+1, channel ch offset by 64*ch.
   function automatic logic [7:0] padPix(input int pr, input int pc, input int ch);
      if (pr < P || pr >= P + H || pc < P || pc >= P + W) return 8'd0;
      return 8'((pr - P) * W + (pc - P) + 1 + 64 * ch);
   endfunction

   task automatic buildExpected(input int stride, input int nch);
      int wpr, wpc;
      logic [255:0] v;
      exp_q.delete();
      wpr = (PW - K) / stride + 1;
      wpc = (PH - K) / stride + 1;
      for (int wr = 0; wr < wpc; wr++)
         for (int wc = 0; wc < wpr; wc++) begin
            v = '0;
            for (int r = 0; r < K; r++)
               for (int c = 0; c < K; c++)
                  for (int ch = 0; ch < nch; ch++)
                     v[((r*K+c)*nch+ch)*8 +: 8] = padPix(wr*stride + K-1-r, wc*stride + K-1-c, ch);
            exp_q.push_back(v);
         end
   endtask

   task automatic drive(input bit sel, input bit v, input int ptr);
      logic [7:0] pix;
      pix = 8'(ptr + 1);
      if (sel) begin
         iv_a = 1'b0; iv_b = v; di_b = pix;
      end else begin
         iv_b = 1'b0; iv_a = v; di_a = {pix + 8'd128, pix + 8'd64, pix};
      end
   endtask

   // sel 0 -> dut_a, 1 -> dut_b; abort_cycle != 0 asserts rst at that cycle of the frame.
   task automatic applyStimulus(input bit sel, input bit gaps, input int abort_cycle);
      int ptr = 0, cycles = 0, hs = 0, late_ready = 0, win_idx = 0;
      bit done = 0, ready_now, valid_now, ov, fd;
      logic [255:0] dout, exp;
      logic [7:0] centers [4];
      centers = '{8'd1, 8'd3, 8'd9, 8'd11};
      buildExpected(sel ? 2 : 1, sel ? 1 : 3);
      @(negedge clk);
      ready_now = sel ? ir_b : ir_a;
      valid_now = 1'b1;
      drive(sel, valid_now, ptr);
      while (!done && cycles < 400) begin
         @(posedge clk);
         if (valid_now && ready_now) begin
            ptr++;
            hs++;
         end
         @(negedge clk);
         cycles++;
         ov   = sel ? ov_b : ov_a;
         fd   = sel ? fd_b : fd_a;
         dout = sel ? {184'd0, do_b} : {40'd0, do_a};
         if (ov) begin
            if (exp_q.size() == 0) checkOutput("extra_window", 1, 0);
            else begin
               exp = exp_q.pop_front();
               checkOutput($sformatf("win%0d", win_idx), dout, exp);
               if (sel && win_idx < 4) checkOutput($sformatf("center%0d", win_idx), dout[32 +: 8], centers[win_idx]);
               if (!sel && win_idx == 0) checkOutput("first_w00", dout[7:0], 8'd6);
`ifdef CNN_WINDOW_LAST_EN
               checkOutput($sformatf("out_last%0d", win_idx), sel ? ol_b : ol_a, exp_q.size() == 0);
`endif
               win_idx++;
            end
         end
`ifdef CNN_WINDOW_LAST_EN
         if (!ov && (sel ? ol_b : ol_a)) checkOutput("out_last_idle", 1, 0);
`endif
         if (fd) begin
            done = 1;
            if (!gaps) checkOutput("done_cycle", cycles, PH * PW + 1);
            if (!sel) checkOutput("last_with_done", ov, 1);
         end
         if (abort_cycle != 0 && cycles == abort_cycle) begin
            rst = 1'b1;
            drive(sel, 1'b0, ptr);
            @(posedge clk);
            @(negedge clk);
            checkOutput("rst_out_valid", ov_a, 0);
            checkOutput("rst_data_out", do_a, 0);
            checkOutput("rst_in_ready", ir_a, 0);
            checkOutput("rst_frame_done", fd_a, 0);
            rst = 1'b0;
            repeat (2) @(negedge clk);
            return;
         end
         ready_now = sel ? ir_b : ir_a;
         if (ptr >= NPIX && ready_now) late_ready++;
         valid_now = (ptr < NPIX) && (!gaps || ($urandom_range(0, 1) == 1));
         drive(sel, valid_now, ptr);
      end
      if (!done) checkOutput("timeout", 0, 1);
      checkOutput("handshakes", hs, NPIX);
      checkOutput("late_ready", late_ready, 0);
      checkOutput("windows_left", exp_q.size(), 0);
      drive(sel, 1'b0, ptr);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      iv_a = 1'b0; iv_b = 1'b0; di_a = '0; di_b = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_ready_a", ir_a, 0);
      checkOutput("reset_valid_a", ov_a, 0);
      checkOutput("reset_done_a", fd_a, 0);
      checkOutput("reset_data_a", do_a, 0);
      checkOutput("reset_ready_b", ir_b, 0);
      checkOutput("reset_data_b", do_b, 0);
      rst = 1'b0;
      @(negedge clk);
      applyStimulus(1'b0, 1'b0, 0);
      applyStimulus(1'b1, 1'b0, 0);
      applyStimulus(1'b1, 1'b1, 0);
      applyStimulus(1'b0, 1'b1, 0);
      // Cycle index k+1 of a frame is spent at padded position k; (3,2) is k = 3*PW+2.
      applyStimulus(1'b0, 1'b0, 3 * PW + 2 + 1);
      applyStimulus(1'b0, 1'b0, 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
